expr_evaluator: RTL and testbench

- Downstream consumer of the ASCII expression stream that feeds the string2 syntax checker.
- Sees the same characters one per valid cycle and computes the integer value of the expression.
- Grammar: decimal numbers, '+', '*', '(' and ')', with '*' binding tighter than '+'.
- The expression is terminated by '=' (8'h3D). The block then presents the result with a one-cycle done pulse and an error flag.

---
 rtl/expr_evaluator.sv | 131 +++++++++++++
 tb/tb_expr_evaluator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/expr_evaluator.sv
// rtl/expr_evaluator.sv - streaming ASCII evaluator for +, *, ( ) expressions terminated by '='.
// Define EXPR_OVF_EN to turn arithmetic overflow into an expression error instead of a silent wrap.
module expr_evaluator #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [7:0]   in,
   input  logic         in_valid,
   output logic [W-1:0] result,
   output logic         done,
   output logic         err
);

`ifdef EXPR_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   localparam int SPW = $clog2(DEPTH + 1);
   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {L_START, L_DIGIT, L_OP, L_LPAR, L_RPAR} last_t;

   logic [W-1:0]   sum, prod, num;
   logic [SPW-1:0] sp, spm1;
   last_t          last;
   logic           errflag;
   logic [W-1:0]   stk_sum  [DEPTH];
   logic [W-1:0]   stk_prod [DEPTH];

   // Arithmetic is carried at 2W+1 bits so the upper half flags overflow.
   logic [2*W:0] prodnum_x, term_x, dig_x;
   logic         pn_ovf, t_ovf, d_ovf, after_op, is_digit;

   always_comb begin
      prodnum_x = {{(W+1){1'b0}}, prod} * {{(W+1){1'b0}}, num};
      term_x    = {{(W+1){1'b0}}, sum} + prodnum_x;
      dig_x     = ({{(W+1){1'b0}}, num} << 3) + ({{(W+1){1'b0}}, num} << 1)
                + {{(2*W-3){1'b0}}, in[3:0]};
      pn_ovf    = OVF_EN && (|prodnum_x[2*W:W]);
      t_ovf     = OVF_EN && (|term_x[2*W:W]);
      d_ovf     = OVF_EN && (|dig_x[2*W:W]);
      after_op  = (last == L_OP) || (last == L_LPAR) || (last == L_START);
      is_digit  = (in >= 8'h30) && (in <= 8'h39);
      spm1      = sp - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         result  <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         sum     <= '0;
         prod    <= W'(1);
         num     <= '0;
         sp      <= '0;
         last    <= L_START;
         errflag <= 1'b0;
      end else begin
         done <= 1'b0;
         if (in_valid) begin
            if (in == 8'h3D) begin
               done <= 1'b1;
               if (errflag || (sp != '0) || after_op || t_ovf) begin
                  err    <= 1'b1;
                  result <= '0;
               end else begin
                  err    <= 1'b0;
                  result <= term_x[W-1:0];
               end
               sum     <= '0;
               prod    <= W'(1);
               num     <= '0;
               sp      <= '0;
               last    <= L_START;
               errflag <= 1'b0;
            end else if (!errflag) begin
               // Any rejected character only raises errflag; working state is discarded at '='.
               if (is_digit) begin
                  if ((last == L_RPAR) || d_ovf) errflag <= 1'b1;
                  else begin
                     num  <= dig_x[W-1:0];
                     last <= L_DIGIT;
                  end
               end else if (in == 8'h2A) begin
                  if (after_op || pn_ovf) errflag <= 1'b1;
                  else begin
                     prod <= prodnum_x[W-1:0];
                     num  <= '0;
                     last <= L_OP;
                  end
               end else if (in == 8'h2B) begin
                  if (after_op || t_ovf) errflag <= 1'b1;
                  else begin
                     sum  <= term_x[W-1:0];
                     prod <= W'(1);
                     num  <= '0;
                     last <= L_OP;
                  end
               end else if (in == 8'h28) begin
                  if ((sp == SPW'(DEPTH)) || (last == L_DIGIT) || (last == L_RPAR)) errflag <= 1'b1;
                  else begin
                     stk_sum[sp[AW-1:0]]  <= sum;
                     stk_prod[sp[AW-1:0]] <= prod;
                     sum  <= '0;
                     prod <= W'(1);
                     num  <= '0;
                     sp   <= sp + 1'b1;
                     last <= L_LPAR;
                  end
               end else if (in == 8'h29) begin
                  if ((sp == '0) || after_op || t_ovf) errflag <= 1'b1;
                  else begin
                     num  <= term_x[W-1:0];
                     sum  <= stk_sum[spm1[AW-1:0]];
                     prod <= stk_prod[spm1[AW-1:0]];
                     sp   <= spm1;
                     last <= L_RPAR;
                  end
               end else begin
                  errflag <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_expr_evaluator.sv
// tb/tb_expr_evaluator.sv - directed self-checking bench for expr_evaluator (DEPTH=4 and DEPTH=2 instances).
module tb_expr_evaluator;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         clr, in_valid;
   logic [7:0]   in;
   logic [W-1:0] result, result2;
   logic         done, done2, err, err2;

   always #5 clk = ~clk;

   expr_evaluator #(.W(W), .DEPTH(4)) dut (
      .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
      .result(result), .done(done), .err(err)
   );

   expr_evaluator #(.W(W), .DEPTH(2)) dut2 (
      .clk(clk), .clr(clr), .in(in), .in_valid(in_valid),
      .result(result2), .done(done2), .err(err2)
   );

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int q_res[$];
   int q_cyc[$];
   bit q_err[$];
   int q2_res[$];
   bit q2_err[$];
   int eq_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done) begin
         q_res.push_back(int'(result));
         q_err.push_back(err);
         q_cyc.push_back(cyc);
      end
      if (done2) begin
         q2_res.push_back(int'(result2));
         q2_err.push_back(err2);
      end
   end

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         in = s[i];
         in_valid = 1'b1;
         if (s[i] == 8'h3D) eq_cyc.push_back(cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in = 8'h00;
      end
   endtask

   task automatic flush();
      q_res.delete(); q_err.delete(); q_cyc.delete(); eq_cyc.delete();
      q2_res.delete(); q2_err.delete();
   endtask

   task automatic get_pulse(output bit got, output int r, output bit e, output int lat);
      got = 1'b0; r = -1; e = 1'bx; lat = -1;
      for (int k = 0; k < 20 && q_res.size() == 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (q_res.size() != 0) begin
         got = 1'b1;
         r = q_res.pop_front();
         e = q_err.pop_front();
         lat = q_cyc.pop_front() - ((eq_cyc.size() != 0) ? eq_cyc.pop_front() : 0);
      end
   endtask

   task automatic test_reset();
      clr = 1'b1; in_valid = 1'b1; in = 8'h35;
      repeat (2) @(negedge clk);
      checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (result2 !== '0 || done2 !== 1'b0 || err2 !== 1'b0) begin
         errors++; $display("FAIL reset_dut2 got=%0d/%b/%b exp=0/0/0", result2, done2, err2);
      end
      clr = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_main();
      bit got, e; int r, lat;
      flush();
      send("57*20+(67*5)*05=");
      idle(3);
      get_pulse(got, r, e, lat);
      checks++; if (!got) begin errors++; $display("FAIL main_done got=0 exp=1"); end
      checks++; if (r !== 2815) begin errors++; $display("FAIL main_result got=%0d exp=2815", r); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL main_err got=%b exp=0", e); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL main_latency got=%0d exp=1", lat); end
      checks++; if (done !== 1'b0 || q_res.size() != 0) begin
         errors++; $display("FAIL main_pulse_width done=%b extra=%0d exp=0/0", done, q_res.size());
      end
      checks++; if (result !== 16'd2815 || err !== 1'b0) begin
         errors++; $display("FAIL main_hold got=%0d/%b exp=2815/0", result, err);
      end
   endtask

   task automatic test_back_to_back();
      bit got, e; int r, lat;
      int exp_r[2] = '{14, 9};
      flush();
      send("2+3*4=");
      send("((1+2)*3)=");
      idle(3);
      for (int i = 0; i < 2; i++) begin
         get_pulse(got, r, e, lat);
         checks++; if (!got || r !== exp_r[i] || e !== 1'b0) begin
            errors++; $display("FAIL b2b_%0d got=%0d/%b/%b exp=%0d/0/1", i, r, e, got, exp_r[i]);
         end
         checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_latency_%0d got=%0d exp=1", i, lat); end
      end
   endtask

   task automatic test_malformed();
      bit got, e; int r, lat;
      string bad[8] = '{")=", "3+=", "(2)3=", "4#=", "()=", "2+*3=", "((((((1))))))=", "(1+2="};
      flush();
      for (int i = 0; i < 8; i++) send(bad[i]);
      idle(3);
      for (int i = 0; i < 8; i++) begin
         get_pulse(got, r, e, lat);
         checks++; if (!got || r !== 0 || e !== 1'b1) begin
            errors++; $display("FAIL malformed_%0d got=%0d/%b/%b exp=0/1/1", i, r, e, got);
         end
      end
   endtask

   task automatic test_depth();
      bit got, e; int r, lat;
      flush();
      send("(((1)))=");
      send("8=");
      idle(3);
      get_pulse(got, r, e, lat);
      checks++; if (!got || r !== 1 || e !== 1'b0) begin
         errors++; $display("FAIL depth4_nest got=%0d/%b/%b exp=1/0/1", r, e, got);
      end
      get_pulse(got, r, e, lat);
      checks++; if (!got || r !== 8 || e !== 1'b0) begin
         errors++; $display("FAIL depth4_after got=%0d/%b/%b exp=8/0/1", r, e, got);
      end
      checks++; if (q2_res.size() != 2) begin
         errors++; $display("FAIL depth2_pulses got=%0d exp=2", q2_res.size());
      end else begin
         checks++; if (q2_res[0] !== 0 || q2_err[0] !== 1'b1) begin
            errors++; $display("FAIL depth2_overflow got=%0d/%b exp=0/1", q2_res[0], q2_err[0]);
         end
         checks++; if (q2_res[1] !== 8 || q2_err[1] !== 1'b0) begin
            errors++; $display("FAIL depth2_recover got=%0d/%b exp=8/0", q2_res[1], q2_err[1]);
         end
      end
   endtask

   task automatic test_gaps();
      bit got, e; int r, lat;
      flush();
      send("1");
      idle(2);
      send("2+");
      idle(1);
      send("3=");
      idle(3);
      get_pulse(got, r, e, lat);
      checks++; if (!got || r !== 15 || e !== 1'b0) begin
         errors++; $display("FAIL gaps got=%0d/%b/%b exp=15/0/1", r, e, got);
      end
   endtask

   task automatic test_clear();
      bit got, e; int r, lat;
      flush();
      send("12+");
      @(negedge clk);
      clr = 1'b1; in = 8'h39; in_valid = 1'b1;
      @(negedge clk);
      clr = 1'b0; in_valid = 1'b0;
      checks++; if (result !== '0 || err !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL clear_state got=%0d/%b/%b exp=0/0/0", result, err, done);
      end
      send("7=");
      idle(3);
      get_pulse(got, r, e, lat);
      checks++; if (!got || r !== 7 || e !== 1'b0) begin
         errors++; $display("FAIL clear_next got=%0d/%b/%b exp=7/0/1", r, e, got);
      end
   endtask

   task automatic test_overflow();
      bit got, e; int r, lat;
`ifdef EXPR_OVF_EN
      int exp_r[3] = '{0, 0, 65535};
      bit exp_e[3] = '{1'b1, 1'b1, 1'b0};
`else
      int exp_r[3] = '{0, 24464, 65535};
      bit exp_e[3] = '{1'b0, 1'b0, 1'b0};
`endif
      flush();
      send("65535+1=");
      send("300*300=");
      send("65535=");
      idle(3);
      for (int i = 0; i < 3; i++) begin
         get_pulse(got, r, e, lat);
         checks++; if (!got || r !== exp_r[i] || e !== exp_e[i]) begin
            errors++; $display("FAIL overflow_%0d got=%0d/%b/%b exp=%0d/%b/1", i, r, e, got, exp_r[i], exp_e[i]);
         end
      end
   endtask

   initial begin
      clr = 1'b1; in_valid = 1'b0; in = 8'h00;
      test_reset();
      test_main();
      test_back_to_back();
      test_malformed();
      test_depth();
      test_gaps();
      test_clear();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
